// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/opcode types and the fetch-stage state encoding.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef enum logic [3:0] {
    op_br  = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
    op_jsr = 4'h4, op_and = 4'h5, op_ldw = 4'h6, op_stw = 4'h7,
    op_rti = 4'h8, op_not = 4'h9, op_rsva = 4'hA, op_rsvb = 4'hB,
    op_jmp = 4'hC, op_shf = 4'hD, op_lea = 4'hE, op_trap = 4'hF
  } lc3b_opcode;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: pipeline register with load/flush; flush only clears valid, payload goes stale.
module ifid_reg
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_load,
  input  logic     i_flush,
  input  lc3b_word i_ir,
  input  lc3b_word i_pc,
  output logic     o_valid,
  output lc3b_word o_ir,
  output lc3b_word o_pc
);
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_ir    <= '0;
      o_pc    <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_ir    <= i_ir;
      o_pc    <= i_pc;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction fetch with one-entry stall buffer and in-flight redirect drop.
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic       clk,
  input  logic       reset,
  output lc3b_word   imem_address,
  output logic       imem_read,
  input  logic       imem_resp,
  input  lc3b_word   imem_rdata,
  input  logic       stall,
  input  logic       redirect,
  input  lc3b_word   redirect_pc,
  output logic       ifid_valid,
  output lc3b_word   ifid_ir,
  output lc3b_word   ifid_pc,
  output lc3b_opcode ifid_opcode
);
  fetch_state r_state, w_state_n;
  lc3b_word r_pc, r_inflight, r_buf_ir, r_buf_pc;
  lc3b_word w_pc_n, w_inflight_n, w_pc_inc, w_ld_ir, w_ld_pc;
  logic w_load, w_flush, w_buf_ld;

  assign w_pc_inc     = r_pc + 16'd2;
  assign imem_read    = !reset && r_state != HOLD;
  assign imem_address = r_state == DROP ? r_inflight : r_pc;
  assign ifid_opcode  = lc3b_opcode'(ifid_ir[15:12]);

  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_inflight_n = r_inflight;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    w_buf_ld     = 1'b0;
    w_ld_ir      = imem_rdata;
    w_ld_pc      = w_pc_inc;
    if (redirect) begin
      w_flush      = 1'b1;
      w_pc_n       = redirect_pc;
      w_state_n    = r_state == HOLD || imem_resp ? FETCH : DROP;
      w_inflight_n = r_state == FETCH && !imem_resp ? r_pc : r_inflight;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_resp) begin
            w_pc_n    = w_pc_inc;
            w_buf_ld  = stall;
            w_load    = !stall;
            w_state_n = stall ? HOLD : FETCH;
          end else begin
            w_flush = !stall;
          end
        end
        HOLD: begin
          w_load    = !stall;
          w_ld_ir   = r_buf_ir;
          w_ld_pc   = r_buf_pc;
          w_state_n = stall ? HOLD : FETCH;
        end
        default: begin
          w_flush   = 1'b1;
          w_state_n = imem_resp ? FETCH : DROP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_buf_ir   <= '0;
      r_buf_pc   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_inflight <= w_inflight_n;
      if (w_buf_ld) begin
        r_buf_ir <= imem_rdata;
        r_buf_pc <= w_pc_inc;
      end
    end
  end

  ifid_reg u_ifid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_flush(w_flush),
    .i_ir   (w_ld_ir),
    .i_pc   (w_ld_pc),
    .o_valid(ifid_valid),
    .o_ir   (ifid_ir),
    .o_pc   (ifid_pc)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenario tests for fetch_stage with hand-computed expectations.
module tb_fetch_stage;
  import lc3b_types::*;
  logic clk = 1'b0;
  logic reset, imem_read, imem_resp, stall, redirect, ifid_valid;
  lc3b_word imem_address, imem_rdata, redirect_pc, ifid_ir, ifid_pc;
  lc3b_opcode ifid_opcode;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_address(imem_address), .imem_read(imem_read),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_ir(ifid_ir),
    .ifid_pc(ifid_pc), .ifid_opcode(ifid_opcode)
  );

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_resp = 1'b0; stall = 1'b0; redirect = 1'b0;
    imem_rdata = '0; redirect_pc = '0;
    step; step;
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", imem_read); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h want 0000", ifid_ir); end
    checks++; if (ifid_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", ifid_pc); end
  endtask

  task automatic test_zero_wait;
    reset = 1'b0; imem_resp = 1'b1;
    #1;
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL zw_first_read: got %b want 1", imem_read); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_address !== 16'(2 * i)) begin errors++; $display("FAIL zw_addr%0d: got %h want %h", i, imem_address, 16'(2 * i)); end
      imem_rdata = 16'h1000 + 16'(i);
      step;
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d: got %b want 1", i, ifid_valid); end
      checks++; if (ifid_ir !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL zw_ir%0d: got %h want %h", i, ifid_ir, 16'h1000 + 16'(i)); end
      checks++; if (ifid_pc !== 16'(2 * i + 2)) begin errors++; $display("FAIL zw_pc%0d: got %h want %h", i, ifid_pc, 16'(2 * i + 2)); end
    end
    checks++; if (ifid_opcode !== op_add) begin errors++; $display("FAIL zw_opcode: got %h want 1", ifid_opcode); end
  endtask

  task automatic advance_to(input lc3b_word target);
    int n = 0;
    imem_resp = 1'b1; stall = 1'b0; redirect = 1'b0;
    while (imem_address !== target && n < 64) begin
      imem_rdata = 16'h2000 | imem_address;
      step;
      n++;
    end
    checks++; if (imem_address !== target) begin errors++; $display("FAIL advance_timeout: got %h want %h", imem_address, target); end
  endtask

  task automatic test_stall_hold;
    advance_to(16'h0010);
    imem_rdata = 16'hB123; stall = 1'b1;
    step;
    imem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL hold_read%0d: got %b want 0", i, imem_read); end
      checks++; if (ifid_ir !== 16'h200E || ifid_pc !== 16'h0010) begin errors++; $display("FAIL hold_ifid%0d: got %h/%h want 200e/0010", i, ifid_ir, ifid_pc); end
      if (i < 2) step;
    end
    stall = 1'b0;
    step;
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL release_valid: got %b want 1", ifid_valid); end
    checks++; if (ifid_ir !== 16'hB123) begin errors++; $display("FAIL release_ir: got %h want b123", ifid_ir); end
    checks++; if (ifid_pc !== 16'h0012) begin errors++; $display("FAIL release_pc: got %h want 0012", ifid_pc); end
    checks++; if (ifid_opcode !== op_rsvb) begin errors++; $display("FAIL release_opcode: got %h want b", ifid_opcode); end
    checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0012) begin errors++; $display("FAIL release_req: got %b/%h want 1/0012", imem_read, imem_address); end
  endtask

  task automatic test_redirect_inflight;
    advance_to(16'h0020);
    imem_resp = 1'b0;
    step;
    redirect = 1'b1; redirect_pc = 16'h0200;
    step;
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0020) begin errors++; $display("FAIL drop_addr%0d: got %b/%h want 1/0020", i, imem_read, imem_address); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drop_valid%0d: got %b want 0", i, ifid_valid); end
      if (i == 0) step;
    end
    imem_resp = 1'b1; imem_rdata = 16'hDEAD;
    step;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL drop_discard: got %b want 0", ifid_valid); end
    checks++; if (imem_address !== 16'h0200) begin errors++; $display("FAIL drop_next_addr: got %h want 0200", imem_address); end
    imem_rdata = 16'h3333;
    step;
    checks++; if (ifid_valid !== 1'b1 || ifid_ir !== 16'h3333 || ifid_pc !== 16'h0202) begin errors++; $display("FAIL drop_refetch: got %b/%h/%h want 1/3333/0202", ifid_valid, ifid_ir, ifid_pc); end
  endtask

  task automatic test_redirect_same_cycle;
    imem_resp = 1'b1; imem_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'h0400;
    step;
    redirect = 1'b0;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL same_valid: got %b want 0", ifid_valid); end
    checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0400) begin errors++; $display("FAIL same_addr: got %b/%h want 1/0400", imem_read, imem_address); end
  endtask

  task automatic test_wrap;
    imem_resp = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
    step;
    redirect = 1'b0;
    checks++; if (imem_address !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr: got %h want fffe", imem_address); end
    imem_rdata = 16'h7777;
    step;
    checks++; if (ifid_valid !== 1'b1 || ifid_ir !== 16'h7777 || ifid_pc !== 16'h0000) begin errors++; $display("FAIL wrap_ifid: got %b/%h/%h want 1/7777/0000", ifid_valid, ifid_ir, ifid_pc); end
    checks++; if (imem_address !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr: got %h want 0000", imem_address); end
  endtask

  task automatic test_reset_mid;
    imem_rdata = 16'h5555;
    step;
    imem_resp = 1'b0; reset = 1'b1;
    #1;
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_read: got %b want 0", imem_read); end
    step;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", ifid_valid); end
    reset = 1'b0;
    #1;
    checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin errors++; $display("FAIL rst_mid_restart: got %b/%h want 1/0000", imem_read, imem_address); end
    imem_resp = 1'b1; imem_rdata = 16'h6001;
    step;
    stall = 1'b1; imem_rdata = 16'h6002;
    step;
    imem_resp = 1'b0;
    checks++; if (imem_read !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_setup: got %b/%b want 0/1", imem_read, ifid_valid); end
    reset = 1'b1;
    step;
    checks++; if (ifid_valid !== 1'b0 || imem_read !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b/%b want 0/0", ifid_valid, imem_read); end
    reset = 1'b0; stall = 1'b0;
    #1;
    checks++; if (imem_read !== 1'b1 || imem_address !== 16'h0000) begin errors++; $display("FAIL rst_hold_restart: got %b/%h want 1/0000", imem_read, imem_address); end
    step;
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_bubble: got %b want 0", ifid_valid); end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_stall_hold;
    test_redirect_inflight;
    test_redirect_same_cycle;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
